// File: rtl/clint_timer_pkg.sv
// rtl/clint_timer_pkg.sv - register map, CTRL field positions and decode helper for clint_timer
//
// Purpose : holds the register offsets, the CTRL bit positions and the mtimecmp
//           reset value, plus a helper that turns a byte address into a register
//           select.
// Ports   : none (package).
package clint_timer_pkg;

  localparam logic [7:0]  ADDR_MTIME_LO      = 8'h00;
  localparam logic [7:0]  ADDR_MTIME_HI      = 8'h04;
  localparam logic [7:0]  ADDR_MTIMECMP_LO   = 8'h08;
  localparam logic [7:0]  ADDR_MTIMECMP_HI   = 8'h0C;
  localparam logic [7:0]  ADDR_CTRL          = 8'h10;
  localparam logic [7:0]  ADDR_STATUS        = 8'h14;
  localparam logic [7:0]  ADDR_MTIME_HI_SNAP = 8'h18;

  localparam int          CTRL_EN_BIT  = 0;
  localparam int          CTRL_DIV_LSB = 8;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_MTIMECMP_LO,
    REG_MTIMECMP_HI,
    REG_CTRL,
    REG_STATUS,
    REG_MTIME_HI_SNAP,
    REG_NONE
  } reg_sel_e;

  // Byte address to register select; bits [1:0] are ignored so any byte
  // offset inside a word hits that word.
  function automatic reg_sel_e decode_addr(input logic [7:0] addr);
    reg_sel_e sel;
    case (addr[7:2])
      ADDR_MTIME_LO[7:2]:      sel = REG_MTIME_LO;
      ADDR_MTIME_HI[7:2]:      sel = REG_MTIME_HI;
      ADDR_MTIMECMP_LO[7:2]:   sel = REG_MTIMECMP_LO;
      ADDR_MTIMECMP_HI[7:2]:   sel = REG_MTIMECMP_HI;
      ADDR_CTRL[7:2]:          sel = REG_CTRL;
      ADDR_STATUS[7:2]:        sel = REG_STATUS;
      ADDR_MTIME_HI_SNAP[7:2]: sel = REG_MTIME_HI_SNAP;
      default:                 sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/_add32.sv
// rtl/_add32.sv - 32-bit adder slice with carry in/out for chaining
//
// Purpose : one 32-bit slice of the mtime incrementer; two are chained to form
//           the full 64-bit add.
// Ports   : a_i, b_i   - 32-bit operands
//           cin_i      - carry in
//           sum_o      - 32-bit sum
//           cout_o     - carry out to the next slice
module _add32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};

endmodule

// File: rtl/timer_prescale.sv
// rtl/timer_prescale.sv - mtime prescaler producing a one-cycle tick every DIV+1 cycles
//
// Purpose : counts pcnt from 0 to DIV while enabled and pulses tick on the
//           cycle pcnt equals DIV.
// Ports   : clk, rst   - clock, asynchronous active-high reset
//           en_i       - count enable (CTRL.EN)
//           div_i      - terminal count (CTRL.DIV)
//           clr_i      - synchronous clear of pcnt (mtime write, DIV change)
//           tick_o     - increment strobe for mtime
module timer_prescale #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] div_i,
  input  logic         clr_i,
  output logic         tick_o
);

  logic [W-1:0] pcnt_q;
  logic [W-1:0] pcnt_d;

  assign tick_o = en_i && (pcnt_q == div_i);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr_i) begin
      pcnt_d = '0;
    end else if (tick_o) begin
      pcnt_d = '0;
    end else if (en_i) begin
      pcnt_d = pcnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - memory-mapped 64-bit machine timer with compare interrupt
//
// Purpose : free-running prescaled mtime, mtimecmp compare, registered timer
//           interrupt, and a single-cycle request/acknowledge register port.
// Ports   : clk, rst   - clock, asynchronous active-high reset
//           req, we    - access request, 1 = write
//           addr       - byte address (bits [1:0] ignored)
//           wdata      - 32-bit write data
//           rdata      - registered read data, valid with ack on reads
//           ack        - one-cycle acknowledge per request
//           ti         - timer interrupt level
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        ti
);

  reg_sel_e              sel;
  logic                  wr_en;
  logic                  rd_en;

  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           mtimecmp_q, mtimecmp_d;
  logic                  en_q, en_d;
  logic [PRESCALE_W-1:0] div_q, div_d;
  logic [31:0]           snap_q, snap_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic                  ti_q, ti_d;

  logic [63:0]           mtime_inc;
  logic                  lo_carry;
  logic                  unused_wrap_carry;
  logic                  tick;
  logic                  pcnt_clr;
  logic [PRESCALE_W-1:0] wdata_div;
  logic [31:0]           ctrl_word;
  logic [31:0]           rd_mux;

  assign sel       = decode_addr(addr);
  assign wr_en     = req && we;
  assign rd_en     = req && !we;
  assign wdata_div = wdata[CTRL_DIV_LSB +: PRESCALE_W];

  // mtime + 1 as two chained 32-bit slices; the final carry is the wrap to 0.
  _add32 u_add_lo (
    .a_i    (mtime_q[31:0]),
    .b_i    (32'd0),
    .cin_i  (1'b1),
    .sum_o  (mtime_inc[31:0]),
    .cout_o (lo_carry)
  );

  _add32 u_add_hi (
    .a_i    (mtime_q[63:32]),
    .b_i    (32'd0),
    .cin_i  (lo_carry),
    .sum_o  (mtime_inc[63:32]),
    .cout_o (unused_wrap_carry)
  );

  // Writing either mtime word restarts the prescale period so the new value
  // is held for a full DIV+1 cycles; a DIV change restarts it as well.
  assign pcnt_clr = wr_en && ((sel == REG_MTIME_LO) || (sel == REG_MTIME_HI) ||
                              ((sel == REG_CTRL) && (wdata_div != div_q)));

  timer_prescale #(
    .W (PRESCALE_W)
  ) u_prescale (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en_q),
    .div_i  (div_q),
    .clr_i  (pcnt_clr),
    .tick_o (tick)
  );

  always_comb begin
    ctrl_word                               = '0;
    ctrl_word[CTRL_EN_BIT]                  = en_q;
    ctrl_word[CTRL_DIV_LSB +: PRESCALE_W]   = div_q;
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_MTIME_LO:      rd_mux = mtime_q[31:0];
      REG_MTIME_HI:      rd_mux = mtime_q[63:32];
      REG_MTIMECMP_LO:   rd_mux = mtimecmp_q[31:0];
      REG_MTIMECMP_HI:   rd_mux = mtimecmp_q[63:32];
      REG_CTRL:          rd_mux = ctrl_word;
      REG_STATUS:        rd_mux = {31'd0, ti_q};
      REG_MTIME_HI_SNAP: rd_mux = snap_q;
      default:           rd_mux = '0;
    endcase
  end

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    div_d      = div_q;
    snap_d     = snap_q;

    if (tick) begin
      mtime_d = mtime_inc;
    end

    // A software write to mtime overrides the increment of the same cycle.
    if (wr_en) begin
      case (sel)
        REG_MTIME_LO:    mtime_d    = {mtime_q[63:32], wdata};
        REG_MTIME_HI:    mtime_d    = {wdata, mtime_q[31:0]};
        REG_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], wdata};
        REG_MTIMECMP_HI: mtimecmp_d = {wdata, mtimecmp_q[31:0]};
        REG_CTRL: begin
          en_d  = wdata[CTRL_EN_BIT];
          div_d = wdata_div;
        end
        default: ;
      endcase
    end

    // Capturing the high word alongside a low-word read gives software a
    // coherent 64-bit sample without a hi/lo/hi retry loop.
    if (rd_en && (sel == REG_MTIME_LO)) begin
      snap_d = mtime_q[63:32];
    end

    rdata_d = rd_en ? rd_mux : 32'd0;
    ack_d   = req;
    ti_d    = en_q && (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      en_q       <= 1'b1;
      div_q      <= '0;
      snap_q     <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      ti_q       <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      div_q      <= div_d;
      snap_q     <= snap_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      ti_q       <= ti_d;
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign ti    = ti_q;

endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - self-checking bench for clint_timer
module tb_clint_timer;

  localparam logic [7:0] A_LO   = 8'h00;
  localparam logic [7:0] A_HI   = 8'h04;
  localparam logic [7:0] A_CLO  = 8'h08;
  localparam logic [7:0] A_CHI  = 8'h0C;
  localparam logic [7:0] A_CTRL = 8'h10;
  localparam logic [7:0] A_STAT = 8'h14;
  localparam logic [7:0] A_SNAP = 8'h18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ack;
  logic        ti;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  clint_timer #(.PRESCALE_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ack   (ack),
    .ti    (ti)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Read: expected value queued at drive time, popped when the ack cycle is sampled.
  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] e);
    string       t;
    logic [31:0] x;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    req = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    req = 1'b0;
    check({tag, "_ack"}, {31'd0, ack}, 32'd1);
    t = tag_q.pop_front();
    x = exp_q.pop_front();
    check(t, rdata, x);
  endtask

  task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    check({tag, "_ack"}, {31'd0, ack}, 32'd1);
    check({tag, "_rdata0"}, rdata, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ti", {31'd0, ti}, 32'd0);
    rst = 1'b0;

    // Free-running, DIV=0: ten edges -> mtime 10 at the read edge.
    idle(10);
    rd("run10_lo", A_LO, 32'd10);
    check("run10_ti", {31'd0, ti}, 32'd0);
    rd("cmp_lo_rst", A_CLO, 32'hFFFF_FFFF);
    rd("ctrl_rst", A_CTRL, 32'h0000_0001);
    rd("status_rst", A_STAT, 32'd0);

    // Compare at 20.
    wr("cmp_hi0", A_CHI, 32'd0);
    wr("cmp_lo20", A_CLO, 32'd20);
    idle(4);
    check("ti_at_mtime20", {31'd0, ti}, 32'd0);
    idle(1);
    check("ti_rise", {31'd0, ti}, 32'd1);
    rd("status_ti", A_STAT, 32'd1);
    wr("cmp_lo1000", A_CLO, 32'd1000);
    check("ti_hold_wr_edge", {31'd0, ti}, 32'd1);
    idle(1);
    check("ti_fall", {31'd0, ti}, 32'd0);

    // DIV=3: one increment per 4 cycles.
    wr("ctrl_div3", A_CTRL, 32'h0000_0301);
    rd("div3_a", A_LO, 32'd25);
    idle(2);
    rd("div3_d", A_LO, 32'd25);
    rd("div3_e", A_LO, 32'd26);
    idle(1);
    wr("ctrl_en0", A_CTRL, 32'h0000_0300);
    idle(5);
    rd("en0_hold", A_LO, 32'd26);
    rd("en0_status", A_STAT, 32'd0);
    rd("en0_ctrl", A_CTRL, 32'h0000_0300);

    // Carry low->high and full 64-bit wrap.
    wr("ctrl_div0", A_CTRL, 32'h0000_0001);
    wr("mt_hi0", A_HI, 32'd0);
    wr("mt_lo_fffe", A_LO, 32'hFFFF_FFFE);
    idle(2);
    rd("carry_lo", A_LO, 32'd0);
    rd("carry_hi", A_HI, 32'd1);
    rd("carry_snap", A_SNAP, 32'd1);
    wr("mt_hi_ff", A_HI, 32'hFFFF_FFFF);
    wr("mt_lo_ff", A_LO, 32'hFFFF_FFFF);
    check("ti_big_mtime", {31'd0, ti}, 32'd1);
    rd("wrap_pre_lo", A_LO, 32'hFFFF_FFFF);
    rd("wrap_pre_snap", A_SNAP, 32'hFFFF_FFFF);
    rd("wrap_lo", A_LO, 32'd1);
    rd("wrap_hi", A_HI, 32'd0);

    // Write on a tick cycle wins; unmapped access; aligned decode.
    wr("mt_lo_100", A_LO, 32'h0000_0100);
    rd("write_wins", A_LO, 32'h0000_0100);
    rd("snap_zero", A_SNAP, 32'd0);
    rd("unmapped_rd", 8'h1C, 32'd0);
    wr("unmapped_wr", 8'h20, 32'hDEAD_BEEF);
    rd("byte_addr_cmp", 8'h0B, 32'd1000);
    check("ti_small_mtime", {31'd0, ti}, 32'd0);
    wr("mt_hi5", A_HI, 32'd5);
    rd("snap_cap_lo", A_LO, 32'h0000_0105);
    rd("snap_cap", A_SNAP, 32'd5);
    check("ti_pre_rst", {31'd0, ti}, 32'd1);

    // Reset while a read acknowledge is pending.
    req = 1'b1; we = 1'b0; addr = A_LO;
    @(negedge clk);
    check("pending_ack", {31'd0, ack}, 32'd1);
    rst = 1'b1; req = 1'b0;
    #1;
    check("midrst_ack", {31'd0, ack}, 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_ti", {31'd0, ti}, 32'd0);
    idle(2);
    check("midrst_no_regen", {31'd0, ack}, 32'd0);
    rst = 1'b0;
    rd("post_snap", A_SNAP, 32'd0);
    rd("post_hi", A_HI, 32'd0);
    rd("post_lo", A_LO, 32'd2);
    rd("post_cmp_lo", A_CLO, 32'hFFFF_FFFF);
    rd("post_cmp_hi", A_CHI, 32'hFFFF_FFFF);
    rd("post_ctrl", A_CTRL, 32'h0000_0001);
    rd("post_status", A_STAT, 32'd0);
    check("post_ti", {31'd0, ti}, 32'd0);
    idle(1);
    check("post_idle_ack", {31'd0, ack}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
